// File: rtl/data_ram_pkg.sv
// Shared constants for the MEM-stage byte RAM (sizes, geometry, size decoding).
// Latency: n/a (package only).
// Backpressure: n/a; optional access-size feature is enabled by DATA_RAM_SIZE_EN.
package data_ram_pkg;

  localparam int DEPTH      = 256;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_WIDTH = 32;
  localparam int LANES      = DATA_WIDTH / 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Lanes touched by an access; lane 0 is byte A (the most significant byte of a word).
  function automatic logic [LANES-1:0] size_lane_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_lane_mask = 4'b0001;
      SIZE_HALF: size_lane_mask = 4'b0011;
      default:   size_lane_mask = 4'b1111;
    endcase
  endfunction

  // Narrow accesses sit in the high lanes of the word view and must move to/from the LSBs.
  function automatic logic [4:0] size_shift(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_shift = 5'd24;
      SIZE_HALF: size_shift = 5'd16;
      default:   size_shift = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_lane_ctrl.sv
// Lane control: wrapped byte indices A..A+3 plus per-lane write enables and read masks.
// Latency: purely combinational.
// Backpressure: none; Size input exists only when DATA_RAM_SIZE_EN is defined.
module data_ram_lane_ctrl
  import data_ram_pkg::*;
(
  input  logic [ADDR_BITS-1:0]            base,
  input  logic                            enable,
  input  logic                            read_write,
`ifdef DATA_RAM_SIZE_EN
  input  logic [1:0]                      size,
`endif
  output logic [LANES-1:0][ADDR_BITS-1:0] idx,
  output logic [LANES-1:0]                we,
  output logic [LANES-1:0]                rmask
);

  logic [LANES-1:0] lanes;

  // Decode which lanes the access covers and split it into read/write qualifiers.
  always_comb begin
`ifdef DATA_RAM_SIZE_EN
    lanes = size_lane_mask(size);
`else
    lanes = '1;
`endif
    we    = (enable && !read_write) ? lanes : '0;
    rmask = (enable &&  read_write) ? lanes : '0;
  end

  // Index arithmetic truncates to ADDR_BITS so words straddling the top wrap to byte 0.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      idx[k] = base + ADDR_BITS'(k);
    end
  end

endmodule

// File: rtl/data_ram_256x8.sv
// 256x8 byte RAM with a 32-bit big-endian port; Size[1:0] added by DATA_RAM_SIZE_EN.
// Latency: combinational read (same time step), write committed at rising clk.
// Backpressure: none; always accepts, writes dropped while reset is high, Mem is never cleared.
module data_ram_256x8
  import data_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] DataOut,
  input  logic                  Enable,
  input  logic                  ReadWrite,
  input  logic [31:0]           Address,
`ifdef DATA_RAM_SIZE_EN
  input  logic [1:0]            Size,
`endif
  input  logic [DATA_WIDTH-1:0] DataIn
);

  logic [7:0] Mem [0:DEPTH-1];

  logic [LANES-1:0][ADDR_BITS-1:0] idx;
  logic [LANES-1:0]                we;
  logic [LANES-1:0]                rmask;
  logic [4:0]                      shamt;
  logic [DATA_WIDTH-1:0]           wdata_word;
  logic [DATA_WIDTH-1:0]           rdata_word;
  logic                            unused_addr;

  // Upper address bits are ignored by design.
  assign unused_addr = ^Address[31:ADDR_BITS];

  data_ram_lane_ctrl u_lane_ctrl (
    .base       (Address[ADDR_BITS-1:0]),
    .enable     (Enable),
    .read_write (ReadWrite),
`ifdef DATA_RAM_SIZE_EN
    .size       (Size),
`endif
    .idx        (idx),
    .we         (we),
    .rmask      (rmask)
  );

`ifdef DATA_RAM_SIZE_EN
  assign shamt = size_shift(Size);
`else
  assign shamt = 5'd0;
`endif

  // Narrow write data is right-aligned on DataIn; lift it into the lanes starting at A.
  assign wdata_word = DataIn << shamt;

  // Commit enabled lanes on the clock edge; reset only suppresses writes, contents persist.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) begin
        if (we[k]) begin
          Mem[idx[k]] <= wdata_word[DATA_WIDTH-1-8*k -: 8];
        end
      end
    end
  end

  // Gather enabled lanes big-endian, then right-align narrow reads; no write bypass.
  always_comb begin
    rdata_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (rmask[k]) begin
        rdata_word[DATA_WIDTH-1-8*k -: 8] = Mem[idx[k]];
      end
    end
    DataOut = reset ? '0 : (rdata_word >> shamt);
  end

endmodule

// File: tb/tb_data_ram_256x8.sv
// Self-checking bench for data_ram_256x8 against a byte-array reference model.
// Latency: reads checked 1 time unit after input change, writes checked after the edge.
// Backpressure: n/a; size-specific steps run only when DATA_RAM_SIZE_EN is defined.
module tb_data_ram_256x8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DataOut;
  logic        Enable;
  logic        ReadWrite;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [1:0]  sz;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [0:255];

  always #5 clk = ~clk;

  data_ram_256x8 dut (
    .clk       (clk),
    .reset     (reset),
    .DataOut   (DataOut),
    .Enable    (Enable),
    .ReadWrite (ReadWrite),
    .Address   (Address),
`ifdef DATA_RAM_SIZE_EN
    .Size      (sz),
`endif
    .DataIn    (DataIn)
  );

  // Number of bytes an access touches.
  function automatic int nbytes(input logic [1:0] s);
`ifdef DATA_RAM_SIZE_EN
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
`else
    if (s == 2'bxx) return 4;
    return 4;
`endif
  endfunction

  // Expected read: bytes A..A+n-1 (mod 256), first byte most significant.
  function automatic logic [31:0] ref_read(input int a, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int j = 0; j < n; j++) v = v * 256 + 32'(model[(a + j) % 256]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [1:0] s);
    @(negedge clk);
    sz = s; Address = a; Enable = 1'b1; ReadWrite = 1'b1;
    #1;
    check(tag, DataOut, ref_read(int'(a[7:0]), nbytes(s)));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int n;
    n = nbytes(s);
    @(negedge clk);
    sz = s; Address = a; DataIn = d; Enable = 1'b1; ReadWrite = 1'b0;
    @(posedge clk);
    #1;
    Enable = 1'b0;
    for (int j = 0; j < n; j++)
      model[(int'(a[7:0]) + j) % 256] = 8'((d >> (8 * (n - 1 - j))) & 32'hFF);
  endtask

  initial begin
    reset = 1'b1; Enable = 1'b0; ReadWrite = 1'b1; Address = '0; DataIn = '0; sz = 2'b10;

    // Preload: 0..17 count up, the rest random so later random reads are defined.
    for (int i = 0; i < 256; i++) begin
      model[i] = (i < 18) ? 8'(i) : 8'($urandom_range(0, 255));
      dut.Mem[i] = model[i];
    end

    // Reset forces zero output even with a read requested.
    @(negedge clk);
    Enable = 1'b1; ReadWrite = 1'b1; Address = 32'h0;
    #1;
    check("reset_out_zero", DataOut, 32'h0);
    @(negedge clk);
    reset = 1'b0; Enable = 1'b0;

    // Sequential reads over the preload, with literal spot checks.
    for (int i = 0; i < 18; i++) begin
      do_read("preload_read", 32'(i), 2'b10);
      if (i == 0)  check("addr0_lit",  DataOut, 32'h00010203);
      if (i == 1)  check("addr1_lit",  DataOut, 32'h01020304);
      if (i == 14) check("addr14_lit", DataOut, 32'h0E0F1011);
      @(negedge clk); Enable = 1'b0;
    end

    // Aligned word write and readback.
    do_write(32'h0000_0010, 32'hDEADBEEF, 2'b10);
    do_read("rd_deadbeef", 32'h0000_0010, 2'b10);
    check("deadbeef_lit", DataOut, 32'hDEADBEEF);
    check("mem16", 32'(dut.Mem[16]), 32'hDE);
    check("mem19", 32'(dut.Mem[19]), 32'hEF);

    // Wrap-around write; upper address bits ignored.
    do_write(32'hFFFF_FFFE, 32'hA1B2C3D4, 2'b10);
    check("mem_fe", 32'(dut.Mem[8'hFE]), 32'hA1);
    check("mem_ff", 32'(dut.Mem[8'hFF]), 32'hB2);
    check("mem_00", 32'(dut.Mem[0]), 32'hC3);
    check("mem_01", 32'(dut.Mem[1]), 32'hD4);
    do_read("rd_wrap", 32'hFFFF_FFFE, 2'b10);
    check("wrap_lit", DataOut, 32'hA1B2C3D4);

    // Output is zero when not reading.
    @(negedge clk);
    Address = 32'h4; Enable = 1'b0; ReadWrite = 1'b1; #1;
    check("en0_zero", DataOut, 32'h0);
    Enable = 1'b1; ReadWrite = 1'b0; DataIn = 32'h0; #1;
    check("rw0_zero", DataOut, 32'h0);
    Enable = 1'b0;

    // Write held under reset is dropped; preloaded data survives.
    @(negedge clk);
    reset = 1'b1; Enable = 1'b1; ReadWrite = 1'b0; Address = 32'h10; DataIn = 32'h11223344;
    @(posedge clk); #1;
    check("reset_write_out", DataOut, 32'h0);
    @(negedge clk);
    reset = 1'b0; Enable = 1'b0;
    do_read("after_reset_10", 32'h10, 2'b10);
    do_read("after_reset_08", 32'h8, 2'b10);

    // Read-during-write at addr 4: old word before the edge, new word after.
    @(negedge clk);
    Address = 32'h4; Enable = 1'b1; ReadWrite = 1'b1; #1;
    check("rdw_old", DataOut, ref_read(4, 4));
    #2;
    ReadWrite = 1'b0; DataIn = 32'hCAFEF00D;
    @(posedge clk); #1;
    ReadWrite = 1'b1;
    model[4] = 8'hCA; model[5] = 8'hFE; model[6] = 8'hF0; model[7] = 8'h0D;
    #1;
    check("rdw_new", DataOut, 32'hCAFEF00D);
    Enable = 1'b0;

`ifdef DATA_RAM_SIZE_EN
    // Narrow accesses.
    do_write(32'h3, 32'h0000005A, 2'b00);
    do_read("sz_word0", 32'h0, 2'b10);
    check("sz_word0_b3", {24'h0, DataOut[7:0]}, 32'h5A);
    do_read("sz_byte3", 32'h3, 2'b00);
    check("sz_byte3_lit", DataOut, 32'h0000005A);
    do_read("sz_half2", 32'h2, 2'b01);
    do_write(32'hFF, 32'h0000ABCD, 2'b01);
    do_read("sz_half_wrap", 32'hFF, 2'b01);
    do_read("sz_size11", 32'hFE, 2'b11);
`endif

    // Random mixed traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0]  s;
      a = $urandom;
`ifdef DATA_RAM_SIZE_EN
      s = 2'($urandom_range(0, 3));
`else
      s = 2'b10;
`endif
      case ($urandom_range(0, 3))
        0: do_write(a, $urandom, s);
        1: begin
          @(negedge clk);
          Address = a; Enable = 1'b0; ReadWrite = 1'($urandom_range(0, 1)); #1;
          check("rand_disabled", DataOut, 32'h0);
        end
        default: do_read("rand_read", a, s);
      endcase
    end

    @(negedge clk);
    Enable = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
